// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the two-requester single-port memory arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned BE_W                 = 4;
  localparam int unsigned DEFAULT_TIMEOUT      = 15;
  localparam int unsigned DEFAULT_STARVE_LIMIT = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Bits needed to hold a counter value in 0..max_val (never less than 1).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = (max_val < 1) ? 1 : $clog2(max_val + 1);
    return w;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the instruction and data requesters, the
// arbiter and the shared memory port. slave = arbiter side, master = the rest.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);

  logic                                  i_req;
  logic [AW-1:0]                         i_addr;
  logic                                  i_ack;
  logic [DW-1:0]                         i_rdata;
  logic                                  i_err;

  logic                                  d_req;
  logic                                  d_we;
  logic [mem_port_arbiter_pkg::BE_W-1:0] d_be;
  logic [AW-1:0]                         d_addr;
  logic [DW-1:0]                         d_wdata;
  logic                                  d_ack;
  logic [DW-1:0]                         d_rdata;
  logic                                  d_err;

  logic                                  mem_req;
  logic                                  mem_we;
  logic [mem_port_arbiter_pkg::BE_W-1:0] mem_be;
  logic [AW-1:0]                         mem_addr;
  logic [DW-1:0]                         mem_wdata;
  logic                                  mem_ack;
  logic [DW-1:0]                         mem_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_ack, i_rdata, i_err,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_ack, d_rdata, d_err,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_ack, i_rdata, i_err,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_ack, d_rdata, d_err,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_arb_prio.sv
// Grant decision: data wins unless the instruction side has been passed over
// STARVE_LIMIT times in a row.
module arb_prio #(
  parameter int unsigned STARVE_LIMIT = 3,
  parameter int unsigned SCW          = 2
) (
  input  logic           i_req,
  input  logic           d_req,
  input  logic [SCW-1:0] starve_cnt,
  output logic           grant_d,
  output logic           grant_i
);

  logic starved;

  assign starved = i_req && d_req && (starve_cnt == SCW'(STARVE_LIMIT));
  assign grant_i = i_req && (!d_req || starved);
  assign grant_d = d_req && !starved;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one single-port memory,
// with starvation protection and a bounded wait for mem_ack.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned TIMEOUT      = DEFAULT_TIMEOUT,
  parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned WCW = cnt_width(TIMEOUT);
  localparam int unsigned SCW = cnt_width(STARVE_LIMIT);

  state_t            state, state_n;
  logic [SCW-1:0]    starve_cnt, starve_n;
  logic [WCW-1:0]    wait_cnt, wait_n;

  logic              i_ack_q, i_ack_n;
  logic              i_err_q, i_err_n;
  logic [DW-1:0]     i_rdata_q, i_rdata_n;
  logic              d_ack_q, d_ack_n;
  logic              d_err_q, d_err_n;
  logic [DW-1:0]     d_rdata_q, d_rdata_n;

  logic              mem_req_q, mem_req_n;
  logic              mem_we_q, mem_we_n;
  logic [BE_W-1:0]   mem_be_q, mem_be_n;
  logic [AW-1:0]     mem_addr_q, mem_addr_n;
  logic [DW-1:0]     mem_wdata_q, mem_wdata_n;

  logic              grant_d, grant_i;

  arb_prio #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .SCW          (SCW)
  ) u_arb_prio (
    .i_req      (bus.i_req),
    .d_req      (bus.d_req),
    .starve_cnt (starve_cnt),
    .grant_d    (grant_d),
    .grant_i    (grant_i)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      wait_cnt    <= '0;
      i_ack_q     <= 1'b0;
      i_err_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state       <= state_n;
      starve_cnt  <= starve_n;
      wait_cnt    <= wait_n;
      i_ack_q     <= i_ack_n;
      i_err_q     <= i_err_n;
      i_rdata_q   <= i_rdata_n;
      d_ack_q     <= d_ack_n;
      d_err_q     <= d_err_n;
      d_rdata_q   <= d_rdata_n;
      mem_req_q   <= mem_req_n;
      mem_we_q    <= mem_we_n;
      mem_be_q    <= mem_be_n;
      mem_addr_q  <= mem_addr_n;
      mem_wdata_q <= mem_wdata_n;
    end
  end

  // Next-state and next-output logic; ack/err are single-cycle pulses.
  always_comb begin
    state_n     = state;
    starve_n    = starve_cnt;
    wait_n      = wait_cnt;
    i_ack_n     = 1'b0;
    i_err_n     = 1'b0;
    i_rdata_n   = i_rdata_q;
    d_ack_n     = 1'b0;
    d_err_n     = 1'b0;
    d_rdata_n   = d_rdata_q;
    mem_req_n   = mem_req_q;
    mem_we_n    = mem_we_q;
    mem_be_n    = mem_be_q;
    mem_addr_n  = mem_addr_q;
    mem_wdata_n = mem_wdata_q;

    case (state)
      IDLE: begin
        if (grant_d) begin
          state_n     = BUSY_D;
          wait_n      = '0;
          mem_req_n   = 1'b1;
          mem_we_n    = bus.d_we;
          mem_be_n    = bus.d_be;
          mem_addr_n  = bus.d_addr;
          mem_wdata_n = bus.d_wdata;
          if (bus.i_req && (starve_cnt != SCW'(STARVE_LIMIT))) begin
            starve_n = starve_cnt + SCW'(1);
          end
        end else if (grant_i) begin
          state_n     = BUSY_I;
          wait_n      = '0;
          starve_n    = '0;
          mem_req_n   = 1'b1;
          mem_we_n    = 1'b0;
          mem_be_n    = '1;
          mem_addr_n  = bus.i_addr;
          mem_wdata_n = '0;
        end
      end

      BUSY_I, BUSY_D: begin
        // A same-cycle mem_ack beats the timeout.
        if (bus.mem_ack) begin
          state_n   = DONE;
          mem_req_n = 1'b0;
          if (state == BUSY_I) begin
            i_ack_n   = 1'b1;
            i_rdata_n = bus.mem_rdata;
          end else begin
            d_ack_n   = 1'b1;
            d_rdata_n = bus.mem_rdata;
          end
        end else if (wait_cnt == WCW'(TIMEOUT)) begin
          state_n   = DONE;
          mem_req_n = 1'b0;
          if (state == BUSY_I) begin
            i_ack_n   = 1'b1;
            i_err_n   = 1'b1;
            i_rdata_n = '0;
          end else begin
            d_ack_n   = 1'b1;
            d_err_n   = 1'b1;
            d_rdata_n = '0;
          end
        end else begin
          wait_n = wait_cnt + WCW'(1);
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.i_ack     = i_ack_q;
  assign bus.i_err     = i_err_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_err     = d_err_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int unsigned TIMEOUT = 15;
  localparam int unsigned SLIMIT  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(
    .AW           (AW),
    .DW           (DW),
    .TIMEOUT      (TIMEOUT),
    .STARVE_LIMIT (SLIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Advance one clock; inputs are then driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    rst = 1'b1;
    step(); step();
    checks++; if ({bus.i_ack, bus.i_err, bus.d_ack, bus.d_err, bus.mem_req, bus.mem_we} !== 6'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=000000", {bus.i_ack, bus.i_err, bus.d_ack, bus.d_err, bus.mem_req, bus.mem_we});
    end
    checks++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.mem_be !== 4'h0) begin
      failures++; $display("FAIL reset_mem_cmd got=%h/%h/%h exp=0/0/0", bus.mem_addr, bus.mem_wdata, bus.mem_be);
    end
    checks++; if (bus.i_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin
      failures++; $display("FAIL reset_rdata got=%h/%h exp=0/0", bus.i_rdata, bus.d_rdata);
    end
    checks++; if (dut.state !== 2'd0 || dut.starve_cnt !== 2'd0 || dut.wait_cnt !== 4'd0) begin
      failures++; $display("FAIL reset_state got=%0d/%0d/%0d exp=0/0/0", dut.state, dut.starve_cnt, dut.wait_cnt);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_instr_read();
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0040;
    step();
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h40 || bus.mem_we !== 1'b0 || bus.mem_be !== 4'hF) begin
      failures++; $display("FAIL ird_cmd got=%b/%h/%b/%h exp=1/00000040/0/f", bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_be);
    end
    step();
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h40 || bus.i_ack !== 1'b0) begin
      failures++; $display("FAIL ird_hold got=%b/%h/%b exp=1/00000040/0", bus.mem_req, bus.mem_addr, bus.i_ack);
    end
    step();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h2008_0005;
    step();
    bus.mem_ack = 1'b0; bus.i_req = 1'b0;
    checks++; if (bus.i_ack !== 1'b1 || bus.i_rdata !== 32'h2008_0005 || bus.i_err !== 1'b0 || bus.mem_req !== 1'b0) begin
      failures++; $display("FAIL ird_done got=%b/%h/%b/%b exp=1/20080005/0/0", bus.i_ack, bus.i_rdata, bus.i_err, bus.mem_req);
    end
    step();
    checks++; if (bus.i_ack !== 1'b0 || bus.i_rdata !== 32'h2008_0005) begin
      failures++; $display("FAIL ird_pulse got=%b/%h exp=0/20080005", bus.i_ack, bus.i_rdata);
    end
  endtask

  task automatic test_simultaneous();
    bus.i_req = 1'b1; bus.i_addr = 32'h80;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEAD_BEEF; bus.d_be = 4'h3;
    step();
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_be !== 4'h3 || bus.mem_addr !== 32'h100 || bus.mem_wdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL sim_data_cmd got=%b/%b/%h/%h/%h exp=1/1/3/00000100/deadbeef", bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata);
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_0011;
    step();
    bus.mem_ack = 1'b0; bus.d_req = 1'b0;
    checks++; if (bus.d_ack !== 1'b1 || bus.i_ack !== 1'b0 || bus.d_rdata !== 32'h11 || bus.mem_req !== 1'b0) begin
      failures++; $display("FAIL sim_data_ack got=%b/%b/%h/%b exp=1/0/00000011/0", bus.d_ack, bus.i_ack, bus.d_rdata, bus.mem_req);
    end
    step();
    checks++; if (bus.mem_req !== 1'b0 || bus.d_ack !== 1'b0) begin
      failures++; $display("FAIL sim_idle got=%b/%b exp=0/0", bus.mem_req, bus.d_ack);
    end
    step();
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h80 || bus.mem_we !== 1'b0 || bus.mem_be !== 4'hF) begin
      failures++; $display("FAIL sim_instr_cmd got=%b/%h/%b/%h exp=1/00000080/0/f", bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_be);
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_0055;
    step();
    bus.mem_ack = 1'b0; bus.i_req = 1'b0;
    checks++; if (bus.i_ack !== 1'b1 || bus.i_rdata !== 32'h55 || bus.d_rdata !== 32'h11) begin
      failures++; $display("FAIL sim_instr_ack got=%b/%h/%h exp=1/00000055/00000011", bus.i_ack, bus.i_rdata, bus.d_rdata);
    end
    step();
  endtask

  task automatic test_starvation();
    logic          exp_data;
    logic [31:0]   exp_addr;
    logic [1:0]    exp_starve;
    bus.i_req = 1'b1; bus.i_addr = 32'h300;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'hF; bus.d_addr = 32'h200; bus.d_wdata = 32'h1234;
    for (int g = 0; g < 4; g++) begin
      step();
      exp_data   = (g < 3);
      exp_addr   = exp_data ? 32'h200 : 32'h300;
      exp_starve = exp_data ? 2'(g + 1) : 2'd0;
      checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== exp_addr || bus.mem_we !== exp_data) begin
        failures++; $display("FAIL starve_grant%0d got=%b/%h/%b exp=1/%h/%b", g, bus.mem_req, bus.mem_addr, bus.mem_we, exp_addr, exp_data);
      end
      checks++; if (dut.starve_cnt !== exp_starve) begin
        failures++; $display("FAIL starve_cnt%0d got=%0d exp=%0d", g, dut.starve_cnt, exp_starve);
      end
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1000 + 32'(g);
      step();
      bus.mem_ack = 1'b0;
      checks++; if (bus.d_ack !== exp_data || bus.i_ack !== !exp_data) begin
        failures++; $display("FAIL starve_ack%0d got=d%b/i%b exp=d%b/i%b", g, bus.d_ack, bus.i_ack, exp_data, !exp_data);
      end
      if (g == 3) begin
        bus.i_req = 1'b0; bus.d_req = 1'b0;
      end
      step();
    end
  endtask

  task automatic test_timeout();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 32'h400;
    step();
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h400) begin
      failures++; $display("FAIL to_cmd got=%b/%b/%h exp=1/0/00000400", bus.mem_req, bus.mem_we, bus.mem_addr);
    end
    for (int k = 1; k <= int'(TIMEOUT); k++) begin
      step();
      checks++; if (bus.mem_req !== 1'b1 || bus.d_ack !== 1'b0) begin
        failures++; $display("FAIL to_wait%0d got=%b/%b exp=1/0", k, bus.mem_req, bus.d_ack);
      end
    end
    step();
    bus.d_req = 1'b0;
    checks++; if (bus.d_ack !== 1'b1 || bus.d_err !== 1'b1 || bus.d_rdata !== 32'h0 || bus.mem_req !== 1'b0) begin
      failures++; $display("FAIL to_ack got=%b/%b/%h/%b exp=1/1/00000000/0", bus.d_ack, bus.d_err, bus.d_rdata, bus.mem_req);
    end
    step();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
    step();
    bus.mem_ack = 1'b0;
    checks++; if (bus.mem_req !== 1'b0 || bus.d_ack !== 1'b0 || bus.i_ack !== 1'b0 || bus.d_rdata !== 32'h0 || dut.state !== 2'd0) begin
      failures++; $display("FAIL to_late_ack got=%b/%b/%b/%h/%0d exp=0/0/0/00000000/0", bus.mem_req, bus.d_ack, bus.i_ack, bus.d_rdata, dut.state);
    end
    step();
  endtask

  task automatic test_boundary();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 32'h500;
    step();
    for (int k = 1; k <= int'(TIMEOUT); k++) begin
      step();
    end
    checks++; if (dut.wait_cnt !== 4'(TIMEOUT) || bus.d_ack !== 1'b0) begin
      failures++; $display("FAIL bnd_wait got=%0d/%b exp=%0d/0", dut.wait_cnt, bus.d_ack, TIMEOUT);
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    step();
    bus.mem_ack = 1'b0; bus.d_req = 1'b0;
    checks++; if (bus.d_ack !== 1'b1 || bus.d_err !== 1'b0 || bus.d_rdata !== 32'hCAFE_F00D) begin
      failures++; $display("FAIL bnd_ack got=%b/%b/%h exp=1/0/cafef00d", bus.d_ack, bus.d_err, bus.d_rdata);
    end
    step();
  endtask

  task automatic test_req_drop();
    bus.i_req = 1'b1; bus.i_addr = 32'h800;
    step();
    bus.i_req = 1'b0;
    step();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h88;
    step();
    bus.mem_ack = 1'b0;
    checks++; if (bus.i_ack !== 1'b1 || bus.i_rdata !== 32'h88 || bus.i_err !== 1'b0) begin
      failures++; $display("FAIL drop_ack got=%b/%h/%b exp=1/00000088/0", bus.i_ack, bus.i_rdata, bus.i_err);
    end
    step();
  endtask

  task automatic test_reset_mid();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'hF; bus.d_addr = 32'h600; bus.d_wdata = 32'h66;
    step();
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h600) begin
      failures++; $display("FAIL rmid_cmd got=%b/%h exp=1/00000600", bus.mem_req, bus.mem_addr);
    end
    step();
    rst = 1'b1; bus.d_req = 1'b0;
    step();
    rst = 1'b0;
    checks++; if (bus.mem_req !== 1'b0 || bus.d_ack !== 1'b0) begin
      failures++; $display("FAIL rmid_abort got=%b/%b exp=0/0", bus.mem_req, bus.d_ack);
    end
    step();
    checks++; if (bus.d_ack !== 1'b0 || bus.mem_req !== 1'b0) begin
      failures++; $display("FAIL rmid_noack got=%b/%b exp=0/0", bus.d_ack, bus.mem_req);
    end
    bus.i_req = 1'b1; bus.i_addr = 32'h700;
    step();
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h700 || bus.mem_we !== 1'b0) begin
      failures++; $display("FAIL rmid_icmd got=%b/%h/%b exp=1/00000700/0", bus.mem_req, bus.mem_addr, bus.mem_we);
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h77;
    step();
    bus.mem_ack = 1'b0; bus.i_req = 1'b0;
    checks++; if (bus.i_ack !== 1'b1 || bus.i_rdata !== 32'h77 || bus.i_err !== 1'b0) begin
      failures++; $display("FAIL rmid_iack got=%b/%h/%b exp=1/00000077/0", bus.i_ack, bus.i_rdata, bus.i_err);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_instr_read();
    test_simultaneous();
    test_starvation();
    test_timeout();
    test_boundary();
    test_req_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
